// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Optional misaligned-address rejection: define MIPS_DMEM_ALIGN_CHK_EN.
module mips_dmem_responder #(
  parameter int width       = 32,
  parameter int depth       = 100,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [width-1:0] req_addr,
  input  logic [width-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [15:0]      test_value
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int IW = width - 2;
  localparam logic [IW-1:0] DEPTH_I = IW'(depth);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept, commit;

  logic             cap_we;
  logic             cap_bad;
  logic [AW-1:0]    cap_slot;
  logic [width-1:0] cap_wdata;

  logic [width-1:0] mem [depth];

  logic [IW-1:0]    req_idx;
  logic             req_bad;
  logic             cm_we;
  logic             cm_bad;
  logic [AW-1:0]    cm_slot;
  logic [width-1:0] cm_wdata;

  assign req_idx = req_addr[width-1:2];

`ifdef MIPS_DMEM_ALIGN_CHK_EN
  assign req_bad = (req_idx >= DEPTH_I) ||
                   (req_addr[1:0] != 2'b00);
`else
  logic unused_lo;
  assign unused_lo = ^req_addr[1:0];
  assign req_bad = (req_idx >= DEPTH_I);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WC == 4'd0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WC;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // zero-wait accesses commit straight from the live request
  always_comb begin
    if (state_q == IDLE) begin
      cm_we    = req_we;
      cm_bad   = req_bad;
      cm_slot  = req_idx[AW-1:0];
      cm_wdata = req_wdata;
    end else begin
      cm_we    = cap_we;
      cm_bad   = cap_bad;
      cm_slot  = cap_slot;
      cm_wdata = cap_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_we    <= 1'b0;
      cap_bad   <= 1'b0;
      cap_slot  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_bad   <= req_bad;
        cap_slot  <= req_idx[AW-1:0];
        cap_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_err <= cm_bad;
        if (cm_bad || cm_we) rsp_rdata <= '0;
        else rsp_rdata <= mem[cm_slot];
        if (!cm_bad && cm_we) mem[cm_slot] <= cm_wdata;
      end
    end
  end

  assign test_value = mem[0][15:0];

endmodule
